// File: rtl/reg_bank_reader_if.sv
// Bus bundle for reg_bank_reader: datapath write port, read request port,
// buffered read result and completed-read counter.
interface reg_bank_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Handshakes: a request transfers on an edge where rd_req && rd_ack; a result
  // transfers on an edge where rd_valid && rd_ready. rd_data is stable while
  // rd_valid && !rd_ready, and rd_ack never depends on rd_req.
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;
  logic [7:0]        rd_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_ready,
    input  rd_ack, rd_valid, rd_data, rd_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_ready,
    output rd_ack, rd_valid, rd_data, rd_count
  );
endinterface

// File: rtl/reg_bank_reader.sv
// Small register bank with a one-entry buffered valid/ready read port,
// write-through bypass on same-address collisions, and a read counter.
module reg_bank_reader #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  reg_bank_reader_if.slave   bus,
  output logic               dbg_state
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] bank [NREGS];
  logic [DATA_W-1:0] rd_data_q;
  logic [7:0]        rd_count_q;
  logic [DATA_W-1:0] sel_data;
  logic              ack;
  logic              accept;
  logic              drain;

  assign ack    = (state == EMPTY) || bus.rd_ready;
  assign accept = bus.rd_req && ack;
  assign drain  = (state == FULL) && bus.rd_ready;

  // A same-cycle write to the address being read wins over the stored value.
  assign sel_data = (bus.wr_en && (bus.wr_addr == bus.rd_addr)) ? bus.wr_data
                                                               : bank[bus.rd_addr];

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (drain && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      rd_data_q  <= '0;
      rd_count_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) rd_data_q  <= sel_data;
      if (drain)  rd_count_q <= rd_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else if (bus.wr_en) begin
      bank[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rd_ack   = ack;
  assign bus.rd_valid = (state == FULL);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_count = rd_count_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed self-checking bench for reg_bank_reader.
module tb_reg_bank_reader;

  logic clk;
  logic reset;
  logic dbg_state;
  int   n_checks;
  int   n_errors;
  logic [7:0] wr_vals [4];

  reg_bank_reader_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  reg_bank_reader #(.DATA_W(8), .NREGS(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_ready = 1'b0;
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_vals[0] = 8'hAA;
    wr_vals[1] = 8'hF0;
    wr_vals[2] = 8'h0F;
    wr_vals[3] = 8'h55;
    reset = 1'b0;
    drive_idle();

    // Reset then idle
    #3;
    check("async_reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    #9;
    reset = 1'b1;
    #1;
    check("reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("reset_data",  {24'd0, bus.rd_data}, 32'h00);
    check("reset_count", {24'd0, bus.rd_count}, 32'd0);
    check("reset_ack",   {31'd0, bus.rd_ack}, 32'd1);
    check("reset_state", {31'd0, dbg_state}, 32'd0);

    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'(i);
      step();
      check("idle_read_valid", {31'd0, bus.rd_valid}, 32'd1);
      check("idle_read_data",  {24'd0, bus.rd_data}, 32'h00);
    end
    bus.rd_req = 1'b0;
    step();
    check("idle_drain_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("idle_count",       {24'd0, bus.rd_count}, 32'd4);

    // Write / read back, back-to-back
    for (int i = 0; i < 4; i++) write_reg(2'(i), wr_vals[i]);
    for (int i = 0; i < 4; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'(i);
      step();
      check("b2b_valid", {31'd0, bus.rd_valid}, 32'd1);
      check("b2b_data",  {24'd0, bus.rd_data}, {24'd0, wr_vals[i]});
    end
    bus.rd_req = 1'b0;
    step();
    check("b2b_drain_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("b2b_count",       {24'd0, bus.rd_count}, 32'd8);

    // Back-pressure
    bus.rd_ready = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 2'd1;
    step();
    check("bp_first_data", {24'd0, bus.rd_data}, 32'hF0);
    bus.rd_addr = 2'd2;
    #1;
    check("bp_ack_low", {31'd0, bus.rd_ack}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", {31'd0, bus.rd_valid}, 32'd1);
      check("bp_hold_data",  {24'd0, bus.rd_data}, 32'hF0);
      check("bp_hold_ack",   {31'd0, bus.rd_ack}, 32'd0);
    end
    check("bp_hold_count", {24'd0, bus.rd_count}, 32'd8);
    bus.rd_ready = 1'b1;
    #1;
    check("bp_ack_high", {31'd0, bus.rd_ack}, 32'd1);
    step();
    check("bp_next_data",  {24'd0, bus.rd_data}, 32'h0F);
    check("bp_next_count", {24'd0, bus.rd_count}, 32'd9);
    bus.rd_req = 1'b0;
    step();
    check("bp_drain_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("bp_drain_count", {24'd0, bus.rd_count}, 32'd10);

    // Write-through bypass
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 8'h3C;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 2'd3;
    step();
    check("bypass_data", {24'd0, bus.rd_data}, 32'h3C);
    bus.wr_en = 1'b0;
    step();
    check("bypass_bank_data", {24'd0, bus.rd_data}, 32'h3C);
    bus.rd_req = 1'b0;
    step();
    check("bypass_count", {24'd0, bus.rd_count}, 32'd12);

    // Writing the buffered register leaves rd_data alone
    bus.rd_ready = 1'b0;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 2'd0;
    step();
    check("buf_first_data", {24'd0, bus.rd_data}, 32'hAA);
    bus.rd_req = 1'b0;
    write_reg(2'd0, 8'h11);
    check("buf_hold_data", {24'd0, bus.rd_data}, 32'hAA);
    bus.rd_ready = 1'b1;
    step();
    check("buf_drain_state", {31'd0, dbg_state}, 32'd0);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 2'd0;
    step();
    check("buf_new_data", {24'd0, bus.rd_data}, 32'h11);
    bus.rd_req = 1'b0;
    step();
    check("buf_count", {24'd0, bus.rd_count}, 32'd14);

    // Counter wrap: 14 so far, continuous reads complete one per edge after the first
    bus.rd_req = 1'b1;
    for (int j = 1; j <= 242; j++) begin
      bus.rd_addr = 2'(j);
      step();
    end
    check("wrap_count_255", {24'd0, bus.rd_count}, 32'd255);
    check("wrap_last_data", {24'd0, bus.rd_data}, 32'h0F);
    step();
    check("wrap_count_0", {24'd0, bus.rd_count}, 32'd0);

    // Async reset with 0x55 held in the buffer
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = 8'h55;
    bus.rd_addr = 2'd3;
    step();
    bus.wr_en    = 1'b0;
    bus.rd_req   = 1'b0;
    bus.rd_ready = 1'b0;
    check("pre_reset_data",  {24'd0, bus.rd_data}, 32'h55);
    check("pre_reset_valid", {31'd0, bus.rd_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, bus.rd_valid}, 32'd0);
    check("mid_reset_data",  {24'd0, bus.rd_data}, 32'h00);
    check("mid_reset_count", {24'd0, bus.rd_count}, 32'd0);
    #1;
    reset = 1'b1;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = 2'(3 - i);
      step();
      check("post_reset_bank", {24'd0, bus.rd_data}, 32'h00);
      check("post_reset_valid", {31'd0, bus.rd_valid}, 32'd1);
    end
    bus.rd_req = 1'b0;
    step();
    check("post_reset_count", {24'd0, bus.rd_count}, 32'd4);

    // Report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
